hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It tracks the destination registers of the instructions in EX, MEM and WB in its own shadow pipeline. From those it drives the 2-bit select inputs of the ALU operand forwarding muxes, stalls IF/ID on load-use hazards, and squashes wrong-path instructions on a taken branch. It sits beside the ID/EX pipeline register and is the only source of stall, flush and forward controls.

---
 rtl/hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Purpose: stall/flush/forward control for the 5-stage core from a shadow EX/MEM/WB pipeline.
// Latency: stall/bubble/flush are combinational; fwd selects come from registers; shadow moves 1 stage per cycle.
// Backpressure: StallIF holds IF/ID on hazards; a taken branch overrides the stall. Build with HAZARD_FORWARD_EN to enable forwarding.
module hazard_ctrl #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             IdValid,
   input  logic [REG_W-1:0] IdRs,
   input  logic [REG_W-1:0] IdRt,
   input  logic             IdUseRs,
   input  logic             IdUseRt,
   input  logic [REG_W-1:0] IdWrReg,
   input  logic             IdRegWrite,
   input  logic             IdMemRead,
   input  logic             ExBranchTaken,
   output logic             StallIF,
   output logic             BubbleEX,
   output logic             FlushID,
   output logic [1:0]       FwdASlc,
   output logic [1:0]       FwdBSlc,
   output logic [CNT_W-1:0] StallCnt
);

   typedef struct packed {
      logic             vld;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic             use_rs;
      logic             use_rt;
      logic [REG_W-1:0] wr;
      logic             reg_write;
      logic             mem_read;
   } ex_t;

   typedef struct packed {
      logic             vld;
      logic [REG_W-1:0] wr;
      logic             reg_write;
      logic             mem_read;
   } mem_t;

   typedef struct packed {
      logic             vld;
      logic [REG_W-1:0] wr;
      logic             reg_write;
   } wb_t;

   ex_t              ex_q, ex_d;
   mem_t             mem_q, mem_d;
   wb_t              wb_q, wb_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             hazard;
   logic             rs_ex, rt_ex;
   logic             unused_shadow;

   // A stage writes r only if it is live, writes the regfile, targets r, and r is not $0.
   function automatic logic is_writer(input logic vld, input logic reg_write,
                                      input logic [REG_W-1:0] wr, input logic [REG_W-1:0] r);
      return vld && reg_write && (wr == r) && (r != '0);
   endfunction

   // Hazard detection and branch squash from the ID inputs and EX/MEM shadow.
   always_comb begin
      hazard = 1'b0;
      rs_ex  = IdUseRs && is_writer(ex_q.vld, ex_q.reg_write, ex_q.wr, IdRs);
      rt_ex  = IdUseRt && is_writer(ex_q.vld, ex_q.reg_write, ex_q.wr, IdRt);
`ifdef HAZARD_FORWARD_EN
      hazard = IdValid && ex_q.mem_read && (rs_ex || rt_ex);
`else
      hazard = IdValid && (rs_ex || rt_ex ||
               (IdUseRs && is_writer(mem_q.vld, mem_q.reg_write, mem_q.wr, IdRs)) ||
               (IdUseRt && is_writer(mem_q.vld, mem_q.reg_write, mem_q.wr, IdRt)));
`endif
      StallIF  = hazard && !ExBranchTaken;
      BubbleEX = hazard || ExBranchTaken;
      FlushID  = ExBranchTaken;
   end

`ifdef HAZARD_FORWARD_EN
   function automatic logic [1:0] fwd_sel(input logic use_src, input logic [REG_W-1:0] r);
      logic [1:0] sel;
      sel = 2'd0;
      if (use_src) begin
         if (is_writer(mem_q.vld, mem_q.reg_write, mem_q.wr, r))
            sel = 2'd1;
         else if (is_writer(wb_q.vld, wb_q.reg_write, wb_q.wr, r))
            sel = 2'd2;
      end
      return sel;
   endfunction

   // Operand mux selects depend only on shadow registers; MEM result beats WB result.
   always_comb begin
      FwdASlc = 2'd0;
      FwdBSlc = 2'd0;
      if (ex_q.vld) begin
         FwdASlc = fwd_sel(ex_q.use_rs, ex_q.rs);
         FwdBSlc = fwd_sel(ex_q.use_rt, ex_q.rt);
      end
   end

   assign unused_shadow = mem_q.mem_read;
`else
   assign FwdASlc = 2'd0;
   assign FwdBSlc = 2'd0;
   assign unused_shadow = ^{ex_q.rs, ex_q.rt, ex_q.use_rs, ex_q.use_rt, mem_q.mem_read, wb_q};
`endif

   // Shadow pipeline advance and saturating stall counter next state.
   always_comb begin
      ex_d = '0;
      if (IdValid && !BubbleEX) begin
         ex_d.vld       = 1'b1;
         ex_d.rs        = IdRs;
         ex_d.rt        = IdRt;
         ex_d.use_rs    = IdUseRs;
         ex_d.use_rt    = IdUseRt;
         ex_d.wr        = IdWrReg;
         ex_d.reg_write = IdRegWrite;
         ex_d.mem_read  = IdMemRead;
      end
      mem_d.vld       = ex_q.vld;
      mem_d.wr        = ex_q.wr;
      mem_d.reg_write = ex_q.reg_write;
      mem_d.mem_read  = ex_q.mem_read;
      wb_d.vld        = mem_q.vld;
      wb_d.wr         = mem_q.wr;
      wb_d.reg_write  = mem_q.reg_write;
      stall_cnt_d     = stall_cnt_q;
      if (StallIF && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // State registers; reset empties every shadow stage and clears the counter.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: self-checking bench for hazard_ctrl against an instruction-level pipeline model.
// Latency: inputs change 1 time unit after a rising edge; outputs are compared 1 unit later.
// Backpressure: an ID instruction is re-presented while the model predicts a stall.
module tb_hazard_ctrl;

   localparam int CNT_W = 10;
   localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HAZARD_FORWARD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic             Clk, Rst_n;
   logic             IdValid, IdUseRs, IdUseRt, IdRegWrite, IdMemRead, ExBranchTaken;
   logic [4:0]       IdRs, IdRt, IdWrReg;
   logic             StallIF, BubbleEX, FlushID;
   logic [1:0]       FwdASlc, FwdBSlc;
   logic [CNT_W-1:0] StallCnt;

   hazard_ctrl #(.REG_W(5), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt),
      .IdUseRs(IdUseRs), .IdUseRt(IdUseRt), .IdWrReg(IdWrReg), .IdRegWrite(IdRegWrite),
      .IdMemRead(IdMemRead), .ExBranchTaken(ExBranchTaken), .StallIF(StallIF),
      .BubbleEX(BubbleEX), .FlushID(FlushID), .FwdASlc(FwdASlc), .FwdBSlc(FwdBSlc),
      .StallCnt(StallCnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      bit       vld;
      bit [4:0] rs, rt;
      bit       urs, urt;
      bit [4:0] wr;
      bit       rw, mr;
   } ins_t;

   // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
   ins_t pipe[3];
   int   m_cnt;
   bit   last_stall;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic ins_t mk(bit [4:0] rs, bit [4:0] rt, bit urs, bit urt,
                               bit [4:0] wr, bit rw, bit mr);
      ins_t i;
      i.vld = 1'b1; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
      i.wr = wr; i.rw = rw; i.mr = mr;
      return i;
   endfunction

   function automatic ins_t nop();
      ins_t i;
      i = '{default: 0};
      return i;
   endfunction

   function automatic bit writes(int s, bit [4:0] r);
      return pipe[s].vld && pipe[s].rw && (pipe[s].wr == r) && (r != 0);
   endfunction

   // Select value is the distance to the nearest producing stage (1 = MEM, 2 = WB).
   function automatic bit [1:0] fwd(bit u, bit [4:0] r);
      if (FWD_EN && pipe[0].vld && u)
         for (int s = 1; s <= 2; s++)
            if (writes(s, r)) return 2'(s);
      return 2'd0;
   endfunction

   function automatic bit model_hazard(ins_t id);
      bit hit  = 1'b0;
      int last = FWD_EN ? 0 : 1;
      for (int s = 0; s <= last; s++) begin
         if (FWD_EN && !pipe[s].mr) continue;
         if ((id.urs && writes(s, id.rs)) || (id.urt && writes(s, id.rt))) hit = 1'b1;
      end
      return id.vld && hit;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 3; s++) pipe[s] = nop();
      m_cnt      = 0;
      last_stall = 1'b0;
   endtask

   task automatic drive(ins_t id, bit br);
      IdValid = id.vld; IdRs = id.rs; IdRt = id.rt; IdUseRs = id.urs; IdUseRt = id.urt;
      IdWrReg = id.wr; IdRegWrite = id.rw; IdMemRead = id.mr; ExBranchTaken = br;
   endtask

   // One pipeline cycle: drive, compare every output, clock, advance the model.
   task automatic apply(ins_t id, bit br);
      bit hz, st, bub;
      drive(id, br);
      #1;
      hz  = model_hazard(id);
      st  = hz && !br;
      bub = hz || br;
      chk("StallIF", StallIF, st);
      chk("BubbleEX", BubbleEX, bub);
      chk("FlushID", FlushID, br);
      chk("FwdASlc", FwdASlc, fwd(pipe[0].urs, pipe[0].rs));
      chk("FwdBSlc", FwdBSlc, fwd(pipe[0].urt, pipe[0].rt));
      chk("StallCnt", StallCnt, m_cnt);
      last_stall = st;
      @(posedge Clk);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (id.vld && !bub) ? id : nop();
      if (st && m_cnt < CMAX) m_cnt++;
      #1;
   endtask

   task automatic issue_hold(ins_t id);
      for (int k = 0; k < 4; k++) begin
         apply(id, 1'b0);
         if (!last_stall) break;
      end
   endtask

   initial begin
      ins_t add3, sub4, lw3, add4, w6, r6, w0, r0, or7, rnd, rd3;
      int   base;
      bit   br;

      add3 = mk(5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
      sub4 = mk(5'd3, 5'd5, 1, 1, 5'd4, 1, 0);
      lw3  = mk(5'd1, 5'd0, 1, 0, 5'd3, 1, 1);
      add4 = mk(5'd3, 5'd3, 1, 1, 5'd4, 1, 0);
      w6   = mk(5'd1, 5'd2, 1, 1, 5'd6, 1, 0);
      r6   = mk(5'd6, 5'd6, 1, 1, 5'd8, 1, 0);
      w0   = mk(5'd1, 5'd2, 1, 1, 5'd0, 1, 1);
      r0   = mk(5'd0, 5'd0, 1, 1, 5'd9, 1, 0);
      or7  = mk(5'd3, 5'd0, 1, 1, 5'd7, 1, 0);
      rd3  = mk(5'd3, 5'd1, 1, 1, 5'd4, 1, 0);

      Rst_n = 1'b0;
      drive(nop(), 1'b0);
      model_reset();
      #2;
      chk("rst_StallIF", StallIF, 0);
      chk("rst_BubbleEX", BubbleEX, 0);
      chk("rst_FlushID", FlushID, 0);
      chk("rst_FwdA", FwdASlc, 0);
      chk("rst_FwdB", FwdBSlc, 0);
      chk("rst_StallCnt", StallCnt, 0);
      #10 Rst_n = 1'b1;
      @(posedge Clk); #1;

      // add $3 then sub $4,$3,$5
      apply(add3, 1'b0);
      issue_hold(sub4);
      repeat (3) apply(nop(), 1'b0);

      // lw $3 then add $4,$3,$3
      base = m_cnt;
      apply(lw3, 1'b0);
      issue_hold(add4);
      repeat (3) apply(nop(), 1'b0);
`ifdef HAZARD_FORWARD_EN
      chk("lw_use_cnt", StallCnt, base + 1);
`else
      chk("lw_use_cnt", StallCnt, base + 2);
`endif

      // $6 producers in MEM and WB, then $0 producer
      apply(w6, 1'b0);
      apply(w6, 1'b0);
      issue_hold(r6);
      repeat (3) apply(nop(), 1'b0);
      base = m_cnt;
      apply(w0, 1'b0);
      apply(r0, 1'b0);
      repeat (2) apply(nop(), 1'b0);
      chk("r0_cnt", StallCnt, base);

      // load-use coinciding with a taken branch
      base = m_cnt;
      apply(lw3, 1'b0);
      apply(add4, 1'b1);
      chk("br_cnt", StallCnt, base);
      repeat (3) apply(nop(), 1'b0);

      // add $3 then or $7,$3,$0
      base = m_cnt;
      apply(add3, 1'b0);
      issue_hold(or7);
      repeat (3) apply(nop(), 1'b0);
`ifdef HAZARD_FORWARD_EN
      chk("or_cnt", StallCnt, base);
`else
      chk("or_cnt", StallCnt, base + 2);
`endif

      // randomized traffic, ID instruction held while stalled
      rnd = nop();
      for (int i = 0; i < 600; i++) begin
         br = ($urandom_range(0, 9) == 0);
         if (!last_stall) begin
            rnd.vld = ($urandom_range(0, 9) != 0);
            rnd.rs  = 5'($urandom_range(0, 7));
            rnd.rt  = 5'($urandom_range(0, 7));
            rnd.urs = 1'($urandom);
            rnd.urt = 1'($urandom);
            rnd.wr  = 5'($urandom_range(0, 7));
            rnd.rw  = 1'($urandom);
            rnd.mr  = rnd.rw && ($urandom_range(0, 2) == 0);
         end
         apply(rnd, br);
      end
      repeat (3) apply(nop(), 1'b0);

      // reset asserted while a stall is being signalled
      apply(lw3, 1'b0);
      drive(rd3, 1'b0);
      #1;
      chk("pre_rst_stall", StallIF, 1);
      Rst_n = 1'b0;
      #1;
      chk("mid_rst_StallIF", StallIF, 0);
      chk("mid_rst_BubbleEX", BubbleEX, 0);
      chk("mid_rst_FlushID", FlushID, 0);
      chk("mid_rst_FwdA", FwdASlc, 0);
      chk("mid_rst_FwdB", FwdBSlc, 0);
      chk("mid_rst_StallCnt", StallCnt, 0);
      model_reset();
      @(negedge Clk) Rst_n = 1'b1;
      @(posedge Clk); #1;
      apply(rd3, 1'b0);
      repeat (3) apply(nop(), 1'b0);

      // drive the counter into saturation and keep stalling
      for (int i = 0; i < 1200 && m_cnt < CMAX; i++) begin
         apply(lw3, 1'b0);
         apply(rd3, 1'b0);
         apply(rd3, 1'b0);
      end
      chk("sat", StallCnt, CMAX);
      repeat (4) begin
         apply(lw3, 1'b0);
         apply(rd3, 1'b0);
         apply(rd3, 1'b0);
      end
      chk("sat_hold", StallCnt, CMAX);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
